// File: rtl/toast_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// toast_hazard_ctrl
// Decode-stage hazard controller. Detects load-use hazards against the
// instruction entering decode, holds IF/ID flushes for a fixed number of
// cycles after a redirect, halts on ECALL/EBREAK until resumed, and keeps a
// saturating count of IF stall cycles.
//
// Ports
//   clk_i, reset_i             clock (rising edge), async active-high reset
//   IF_rs1_addr_i/rs2_addr_i   source registers of the instruction entering ID
//   IF_rs2_used_i              entering instruction reads rs2
//   ID_mem_rd_en_i, ID_rd_addr_i  load / destination in the ID/EX register
//   ID_exception_i             ECALL/EBREAK in the ID/EX register
//   EX_redirect_i              taken branch/jump resolved this cycle
//   resume_i                   releases HALT
//   clear_count_i              synchronous clear of stall_count_o
//   IF_stall_o, ID_stall_o     hold IF / bubble ID (combinational)
//   IF_flush_o, ID_flush_o     flush fetched instr / ID/EX reg (combinational)
//   halted_o                   controller is in HALT (combinational)
//   stall_count_o              saturating count of IF stall cycles (registered)
// -----------------------------------------------------------------------------
module toast_hazard_ctrl #(
   parameter int unsigned REGFILE_ADDR_WIDTH = 5,
   parameter int unsigned LOAD_STALL_CYCLES  = 1,
   parameter int unsigned FLUSH_CYCLES       = 2,
   parameter int unsigned COUNT_WIDTH        = 16
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [REGFILE_ADDR_WIDTH-1:0] IF_rs1_addr_i,
   input  logic [REGFILE_ADDR_WIDTH-1:0] IF_rs2_addr_i,
   input  logic                          IF_rs2_used_i,
   input  logic                          ID_mem_rd_en_i,
   input  logic [REGFILE_ADDR_WIDTH-1:0] ID_rd_addr_i,
   input  logic                          ID_exception_i,
   input  logic                          EX_redirect_i,
   input  logic                          resume_i,
   input  logic                          clear_count_i,
   output logic                          IF_stall_o,
   output logic                          ID_stall_o,
   output logic                          IF_flush_o,
   output logic                          ID_flush_o,
   output logic                          halted_o,
   output logic [COUNT_WIDTH-1:0]        stall_count_o
);

   localparam int unsigned MAX_CYCLES = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ?
                                        LOAD_STALL_CYCLES : FLUSH_CYCLES;
   localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] LSTALL_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LSTALL = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_next;
   logic [COUNT_WIDTH-1:0] r_stall_count;

   logic w_hazard;
   logic w_stall;
   logic w_if_flush;
   logic w_id_flush;
   logic w_halted;

   // Load-use hazard: x0 never creates a dependency.
   assign w_hazard = ID_mem_rd_en_i && (ID_rd_addr_i != '0) &&
                     ((ID_rd_addr_i == IF_rs1_addr_i) ||
                      (IF_rs2_used_i && (ID_rd_addr_i == IF_rs2_addr_i)));

   // State and down-counter register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= ST_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state and control decode.
   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      w_stall      = 1'b0;
      w_if_flush   = 1'b0;
      w_id_flush   = 1'b0;
      w_halted     = 1'b0;

      case (r_state)
         ST_RUN, ST_LSTALL: begin
            if (EX_redirect_i) begin
               // Redirect also aborts an in-progress load stall.
               w_if_flush = 1'b1;
               w_id_flush = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  w_next_state = ST_FLUSH;
                  w_cnt_next   = FLUSH_LOAD;
               end else begin
                  w_next_state = ST_RUN;
               end
            end else if (r_state == ST_LSTALL) begin
               w_stall    = 1'b1;
               w_cnt_next = r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE) begin
                  w_next_state = ST_RUN;
               end
            end else if (ID_exception_i) begin
               w_stall      = 1'b1;
               w_next_state = ST_HALT;
            end else if (w_hazard) begin
               w_stall = 1'b1;
               if (LOAD_STALL_CYCLES > 1) begin
                  w_next_state = ST_LSTALL;
                  w_cnt_next   = LSTALL_LOAD;
               end
            end
         end

         ST_FLUSH: begin
            // Instruction being flushed is dead: exceptions/hazards ignored.
            w_if_flush = 1'b1;
            w_id_flush = 1'b1;
            if (EX_redirect_i) begin
               w_cnt_next = FLUSH_LOAD;
            end else begin
               w_cnt_next = r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE) begin
                  w_next_state = ST_RUN;
               end
            end
         end

         ST_HALT: begin
            w_stall  = 1'b1;
            w_halted = 1'b1;
            if (resume_i) begin
               // Retire the ECALL slot on the way out.
               w_id_flush   = 1'b1;
               w_next_state = ST_RUN;
            end
         end

         default: begin
            w_next_state = ST_RUN;
            w_cnt_next   = '0;
         end
      endcase

      // Flush dominates stall.
      if (w_if_flush) begin
         w_stall = 1'b0;
      end
   end

   // Saturating stall-cycle counter; clear has priority.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_stall_count <= '0;
      end else if (clear_count_i) begin
         r_stall_count <= '0;
      end else if (w_stall && (r_stall_count != '1)) begin
         r_stall_count <= r_stall_count + COUNT_WIDTH'(1);
      end
   end

   // Controls are forced low while reset is asserted.
   assign IF_stall_o    = w_stall    & ~reset_i;
   assign ID_stall_o    = w_stall    & ~reset_i;
   assign IF_flush_o    = w_if_flush & ~reset_i;
   assign ID_flush_o    = w_id_flush & ~reset_i;
   assign halted_o      = w_halted   & ~reset_i;
   assign stall_count_o = r_stall_count;

endmodule
